// File: rtl/fetch_align_pkg.sv
// Shared types and sizing for the fetch-to-instr_queue aligner.
package fetch_align_pkg;

    localparam int FETCH_WIDTH     = 4;
    localparam int PC_WIDTH        = 32;
    localparam int FETCH_LANE_BITS = $clog2(FETCH_WIDTH);
    localparam int BUF_DEPTH       = 2 * FETCH_WIDTH;
    localparam int CNT_BITS        = $clog2(BUF_DEPTH + 1);
    localparam int ADD_BITS        = $clog2(FETCH_WIDTH + 1);

    typedef struct packed {
        logic                valid;
        logic                fault;
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
    } aligned_instr_t;

    localparam int ENTRY_BITS = $bits(aligned_instr_t);

    // Address of lane 0 of the fetch block containing pc.
    function automatic logic [PC_WIDTH-1:0] block_base(input logic [PC_WIDTH-1:0] pc);
        logic [PC_WIDTH-1:0] base;
        base = pc;
        base[FETCH_LANE_BITS+1:0] = '0;
        return base;
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Fetch-side and instr_queue-side handshake bundle of the aligner.
interface fetch_align_if;
    import fetch_align_pkg::*;

    logic                                   i_fetch_valid;
    logic                                   o_fetch_ready;
    logic [PC_WIDTH-1:0]                    i_fetch_pc;
    logic [32*FETCH_WIDTH-1:0]              i_fetch_data;
    logic [FETCH_LANE_BITS-1:0]             i_fetch_end_lane;
    logic                                   i_fetch_fault;
    logic                                   i_iq_can_enqueue;
    logic                                   o_iq_enqueue;
    aligned_instr_t [FETCH_WIDTH-1:0]       o_instrs;

    modport slave (
        input  i_fetch_valid, i_fetch_pc, i_fetch_data, i_fetch_end_lane,
               i_fetch_fault, i_iq_can_enqueue,
        output o_fetch_ready, o_iq_enqueue, o_instrs
    );

    modport master (
        output i_fetch_valid, i_fetch_pc, i_fetch_data, i_fetch_end_lane,
               i_fetch_fault, i_iq_can_enqueue,
        input  o_fetch_ready, o_iq_enqueue, o_instrs
    );

endinterface

// File: rtl/fetch_align_chk.sv
// Invariant checks for the aligner staging buffer.
module fetch_align_chk
    import fetch_align_pkg::*;
(
    input logic                i_clk,
    input logic                i_rst,
    input logic [CNT_BITS-1:0] count_d_i
);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        count_d_i <= CNT_BITS'(BUF_DEPTH));

endmodule

// File: rtl/fetch_align_compact.sv
// Drops unwanted lanes of one fetch block and packs survivors toward lane 0.
module fetch_align_compact
    import fetch_align_pkg::*;
(
    input  logic [32*FETCH_WIDTH-1:0]        block_i,
    input  logic [PC_WIDTH-1:0]              pc_i,
    input  logic [FETCH_LANE_BITS-1:0]       start_i,
    input  logic [FETCH_LANE_BITS-1:0]       end_lane_i,
    input  logic                             fault_i,
    output aligned_instr_t [FETCH_WIDTH-1:0] entries_o,
    output logic [ADD_BITS-1:0]              added_o
);

    logic [PC_WIDTH-1:0] base_s;
    logic [ADD_BITS-1:0] pos_s;

    // Prefix-sum over the keep mask: each kept lane lands at the number of kept lanes before it.
    always_comb begin
        entries_o = '0;
        pos_s     = '0;
        base_s    = block_base(pc_i);
        if (fault_i) begin
            entries_o[0].valid = 1'b1;
            entries_o[0].fault = 1'b1;
            entries_o[0].pc    = pc_i;
            entries_o[0].instr = 32'h0000_0000;
            pos_s              = ADD_BITS'(1);
        end else begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if ((FETCH_LANE_BITS'(k) >= start_i) && (FETCH_LANE_BITS'(k) <= end_lane_i)) begin
                    entries_o[pos_s[FETCH_LANE_BITS-1:0]].valid = 1'b1;
                    entries_o[pos_s[FETCH_LANE_BITS-1:0]].fault = 1'b0;
                    entries_o[pos_s[FETCH_LANE_BITS-1:0]].pc    = base_s + (PC_WIDTH'(k) << 2);
                    entries_o[pos_s[FETCH_LANE_BITS-1:0]].instr = block_i[32*k +: 32];
                    pos_s = pos_s + ADD_BITS'(1);
                end else begin
                    pos_s = pos_s;
                end
            end
        end
        added_o = pos_s;
    end

endmodule

// File: rtl/fetch_align.sv
// Fetch-to-IQ aligner: stages compacted fetch lanes and emits lane-0-aligned bundles.
module fetch_align
    import fetch_align_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    fetch_align_if.slave  bus
);

    logic [CNT_BITS-1:0]              count_q, count_d;
    aligned_instr_t [BUF_DEPTH-1:0]   buf_q, buf_d;
    aligned_instr_t [BUF_DEPTH-1:0]   shift_s, app_s;
    aligned_instr_t [FETCH_WIDTH-1:0] comp_s, instrs_s;
    logic [ADD_BITS-1:0]              added_s;
    logic [CNT_BITS-1:0]              n_s, remain_s, add_cnt_s;
    logic                             ready_s, accept_s, emit_s;

    fetch_align_compact u_compact (
        .block_i    (bus.i_fetch_data),
        .pc_i       (bus.i_fetch_pc),
        .start_i    (bus.i_fetch_pc[2 +: FETCH_LANE_BITS]),
        .end_lane_i (bus.i_fetch_end_lane),
        .fault_i    (bus.i_fetch_fault),
        .entries_o  (comp_s),
        .added_o    (added_s)
    );

    // Handshake: ready looks only at the registered count; partial bundles wait for an idle fetch.
    always_comb begin
        ready_s  = ~i_rst & ~i_flush & (count_q <= CNT_BITS'(FETCH_WIDTH));
        accept_s = ready_s & bus.i_fetch_valid;
        emit_s   = ~i_rst & ~i_flush & bus.i_iq_can_enqueue & (count_q != '0) &
                   ((count_q >= CNT_BITS'(FETCH_WIDTH)) | ~bus.i_fetch_valid);
        if (!emit_s) begin
            n_s = '0;
        end else if (count_q >= CNT_BITS'(FETCH_WIDTH)) begin
            n_s = CNT_BITS'(FETCH_WIDTH);
        end else begin
            n_s = count_q;
        end
    end

    // Next state: drop emitted head entries, then append new entries right behind the survivors.
    always_comb begin
        remain_s = count_q - n_s;
        shift_s  = buf_q >> (ENTRY_BITS * n_s);
        app_s    = '0;
        if (accept_s) begin
            app_s[FETCH_WIDTH-1:0] = comp_s;
            add_cnt_s              = CNT_BITS'(added_s);
        end else begin
            add_cnt_s              = '0;
        end
        buf_d   = shift_s | (app_s << (ENTRY_BITS * remain_s));
        count_d = remain_s + add_cnt_s;
    end

    // Bundle to the IQ: head entries in program order, unused lanes zeroed.
    always_comb begin
        instrs_s = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (emit_s && (CNT_BITS'(j) < n_s)) begin
                instrs_s[j] = buf_q[j];
            end else begin
                instrs_s[j] = '0;
            end
        end
    end

    assign bus.o_fetch_ready = ready_s;
    assign bus.o_iq_enqueue  = emit_s;
    assign bus.o_instrs      = instrs_s;

    // Staging state; reset and flush both empty and clear the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            buf_q   <= '0;
        end else if (i_flush) begin
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    fetch_align_chk u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .count_d_i (count_d)
    );

endmodule
